joint_step_generator: RTL and testbench

Converts each new joint-angle pair from the inverse-kinematics stage (13-bit signed θ1/θ2, 1 LSB = 1 microstep) into step/direction pulse trains for the two SCARA joint stepper drivers. It tracks the absolute microstep position of each joint and computes the signed move for each joint. Both joints step concurrently on a shared step clock. It sits directly downstream of the angle calculator and upstream of the motor-driver pins.

---
 rtl/scara_motion_pkg.sv | 32 +++
 rtl/step_channel.sv | 71 +++++++
 rtl/joint_step_generator.sv | 175 +++++++++++++++++
 tb/tb_joint_step_generator.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scara_motion_pkg.sv
// Shared types and constants for the SCARA joint motion blocks.
// Soft-limit bounds apply only when SOFT_LIMIT_EN is defined.
package scara_motion_pkg;

    localparam int ANGLE_W = 13;

    typedef logic signed [ANGLE_W-1:0] angle_t;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_LOAD      = 3'd1;
    localparam state_t S_DIR_SETUP = 3'd2;
    localparam state_t S_STEP_HIGH = 3'd3;
    localparam state_t S_STEP_LOW  = 3'd4;
    localparam state_t S_DONE      = 3'd5;

    localparam angle_t TH1_MIN = -13'sd3000;
    localparam angle_t TH1_MAX =  13'sd3000;
    localparam angle_t TH2_MIN = -13'sd3500;
    localparam angle_t TH2_MAX =  13'sd3500;

    function automatic angle_t clamp_angle(
        input angle_t v,
        input angle_t lo,
        input angle_t hi
    );
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/step_channel.sv
// One joint: absolute position, remaining step count, direction
// and step output, driven by load/step/clear strobes from the FSM.
module step_channel
    import scara_motion_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   load_i,
    input  logic   step_i,
    input  logic   clr_i,
    input  angle_t target_i,
    output angle_t pos_o,
    output logic   dir_o,
    output logic   step_o,
    output logic   active_o,
    output logic   mag_zero_o
);

    angle_t               pos_q, pos_d;
    logic [ANGLE_W-1:0]   cnt_q, cnt_d;
    logic                 dir_q, dir_d;
    logic                 step_q, step_d;
    logic signed [ANGLE_W:0] delta;
    logic [ANGLE_W-1:0]   mag;

    // 14-bit difference so the full -4096..4095 swing cannot overflow
    always_comb begin
        delta = {target_i[ANGLE_W-1], target_i}
              - {pos_q[ANGLE_W-1], pos_q};
        mag = delta[ANGLE_W] ? ANGLE_W'(-delta)
                             : ANGLE_W'(delta);
    end

    always_comb begin
        pos_d  = pos_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        step_d = step_q;
        if (load_i) begin
            dir_d = ~delta[ANGLE_W];
            cnt_d = mag;
        end else if (step_i && cnt_q != '0) begin
            cnt_d  = cnt_q - 1'b1;
            pos_d  = dir_q ? pos_q + angle_t'(1)
                           : pos_q - angle_t'(1);
            step_d = 1'b1;
        end
        if (clr_i) step_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q  <= '0;
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            step_q <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            step_q <= step_d;
        end
    end

    assign pos_o      = pos_q;
    assign dir_o      = dir_q;
    assign step_o     = step_q;
    assign active_o   = (cnt_q != '0);
    assign mag_zero_o = (mag == '0);

endmodule

// File: rtl/joint_step_generator.sv
// Two-joint step/dir generator with shared slot timer and FSM.
// Define SOFT_LIMIT_EN to clamp targets to the package bounds.
module joint_step_generator
    import scara_motion_pkg::*;
#(
    parameter int STEP_PERIOD  = 5000,
    parameter int PULSE_CYCLES = 100,
    parameter int DIR_SETUP    = 50
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               anglesValid,
    input  logic signed [12:0] th1,
    input  logic signed [12:0] th2,
    output logic               step1,
    output logic               step2,
    output logic               dir1,
    output logic               dir2,
    output logic signed [12:0] pos1,
    output logic signed [12:0] pos2,
    output logic               busy,
    output logic               moveDone,
    output logic               overrun,
    output logic               limitHit
);

    localparam int TMAX = (STEP_PERIOD > DIR_SETUP)
                        ? STEP_PERIOD : DIR_SETUP;
    localparam int TW = $clog2(TMAX + 1);
    localparam logic [TW-1:0] T_DIR  = TW'(DIR_SETUP - 1);
    localparam logic [TW-1:0] T_HIGH = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] T_LOW  =
        TW'(STEP_PERIOD - PULSE_CYCLES - 1);

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            av_q, av_prev_q;
    angle_t          tgt1_q, tgt1_d, tgt2_q, tgt2_d;
    angle_t          eff1, eff2;
    logic            overrun_q, limit_q;
    logic            edge_w, clamp_hit;
    logic            load_w, step_w, clr_w;
    logic            act1, act2, zero1, zero2;

    assign edge_w = av_q & ~av_prev_q;

`ifdef SOFT_LIMIT_EN
    assign eff1 = clamp_angle(tgt1_q, TH1_MIN, TH1_MAX);
    assign eff2 = clamp_angle(tgt2_q, TH2_MIN, TH2_MAX);
    assign clamp_hit = (eff1 != tgt1_q) | (eff2 != tgt2_q);
`else
    assign eff1 = tgt1_q;
    assign eff2 = tgt2_q;
    assign clamp_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        load_w  = 1'b0;
        step_w  = 1'b0;
        clr_w   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (edge_w) state_d = S_LOAD;
            end
            S_LOAD: begin
                load_w  = 1'b1;
                state_d = (zero1 && zero2) ? S_DONE
                                           : S_DIR_SETUP;
            end
            S_DIR_SETUP: begin
                if (timer_q == T_DIR) begin
                    state_d = S_STEP_HIGH;
                    step_w  = 1'b1;
                end
            end
            S_STEP_HIGH: begin
                if (timer_q == T_HIGH) begin
                    state_d = S_STEP_LOW;
                    clr_w   = 1'b1;
                end
            end
            S_STEP_LOW: begin
                if (timer_q == T_LOW) begin
                    if (act1 || act2) begin
                        state_d = S_STEP_HIGH;
                        step_w  = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Timer restarts on every state change, so it counts cycles-in-state
    always_comb begin
        if (state_d != state_q || state_q == S_IDLE)
            timer_d = '0;
        else
            timer_d = timer_q + 1'b1;
    end

    always_comb begin
        tgt1_d = tgt1_q;
        tgt2_d = tgt2_q;
        if (state_q == S_IDLE && edge_w) begin
            tgt1_d = th1;
            tgt2_d = th2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            av_q      <= 1'b0;
            av_prev_q <= 1'b0;
            tgt1_q    <= '0;
            tgt2_q    <= '0;
            overrun_q <= 1'b0;
            limit_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            av_q      <= anglesValid;
            av_prev_q <= av_q;
            tgt1_q    <= tgt1_d;
            tgt2_q    <= tgt2_d;
            overrun_q <= overrun_q
                       | (edge_w & (state_q != S_IDLE));
            limit_q   <= limit_q
                       | ((state_q == S_LOAD) & clamp_hit);
        end
    end

    step_channel u_ch1 (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load_w),
        .step_i     (step_w),
        .clr_i      (clr_w),
        .target_i   (eff1),
        .pos_o      (pos1),
        .dir_o      (dir1),
        .step_o     (step1),
        .active_o   (act1),
        .mag_zero_o (zero1)
    );

    step_channel u_ch2 (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load_w),
        .step_i     (step_w),
        .clr_i      (clr_w),
        .target_i   (eff2),
        .pos_o      (pos2),
        .dir_o      (dir2),
        .step_o     (step2),
        .active_o   (act2),
        .mag_zero_o (zero2)
    );

    assign busy = (state_q == S_LOAD)
               || (state_q == S_DIR_SETUP)
               || (state_q == S_STEP_HIGH)
               || (state_q == S_STEP_LOW);
    assign moveDone = (state_q == S_DONE);
    assign overrun  = overrun_q;
    assign limitHit = limit_q;

endmodule

// File: tb/tb_joint_step_generator.sv
// Bench for joint_step_generator: vector table, timing corners,
// overrun, reset mid-move and randomized moves vs a position model.
module tb_joint_step_generator;

    localparam int SP = 4;
    localparam int PC = 2;
    localparam int DS = 3;

    logic clk = 1'b0;
    logic reset;
    logic anglesValid;
    logic signed [12:0] th1, th2;
    logic step1, step2, dir1, dir2;
    logic signed [12:0] pos1, pos2;
    logic busy, moveDone, overrun, limitHit;

    joint_step_generator #(
        .STEP_PERIOD  (SP),
        .PULSE_CYCLES (PC),
        .DIR_SETUP    (DS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .anglesValid (anglesValid),
        .th1         (th1),
        .th2         (th2),
        .step1       (step1),
        .step2       (step2),
        .dir1        (dir1),
        .dir2        (dir2),
        .pos1        (pos1),
        .pos2        (pos2),
        .busy        (busy),
        .moveDone    (moveDone),
        .overrun     (overrun),
        .limitHit    (limitHit)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int up1 = 0, dn1 = 0, up2 = 0, dn2 = 0, md = 0;
    logic pv1 = 1'b0, pv2 = 1'b0;

    always @(negedge clk) begin
        if (step1 && !pv1) begin
            if (dir1) up1 <= up1 + 1;
            else      dn1 <= dn1 + 1;
        end
        if (step2 && !pv2) begin
            if (dir2) up2 <= up2 + 1;
            else      dn2 <= dn2 + 1;
        end
        if (moveDone) md <= md + 1;
        pv1 <= step1;
        pv2 <= step2;
    end

    task automatic check(input string nm, input int act,
                         input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic wait_done(input int md0, input int bound,
                             input string nm);
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            if (md != md0) break;
        end
        if (md == md0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no moveDone in %0d cycles",
                     nm, bound);
        end
        repeat (3) @(posedge clk);
    endtask

    function automatic int clampv(int v, int lo, int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int lim1(int v);
`ifdef SOFT_LIMIT_EN
        return clampv(v, -3000, 3000);
`else
        return v;
`endif
    endfunction

    function automatic int lim2(int v);
`ifdef SOFT_LIMIT_EN
        return clampv(v, -3500, 3500);
`else
        return v;
`endif
    endfunction

    task automatic do_move(input string nm,
                           input int t1, input int t2,
                           input int ep1, input int ep2,
                           input int eu1, input int ed1,
                           input int eu2, input int ed2,
                           input int elh);
        int s_u1, s_d1, s_u2, s_d2, s_md, nmax, bound;
        @(negedge clk);
        s_u1 = up1; s_d1 = dn1; s_u2 = up2; s_d2 = dn2;
        s_md = md;
        th1 = 13'(t1);
        th2 = 13'(t2);
        anglesValid = 1'b1;
        nmax = eu1 + ed1;
        if (eu2 + ed2 > nmax) nmax = eu2 + ed2;
        bound = 40 + DS + 2 * SP * (nmax + 1);
        wait_done(s_md, bound, nm);
        @(negedge clk);
        anglesValid = 1'b0;
        check({nm, ".moveDone"}, md - s_md, 1);
        check({nm, ".up1"}, up1 - s_u1, eu1);
        check({nm, ".dn1"}, dn1 - s_d1, ed1);
        check({nm, ".up2"}, up2 - s_u2, eu2);
        check({nm, ".dn2"}, dn2 - s_d2, ed2);
        check({nm, ".pos1"}, int'(pos1), ep1);
        check({nm, ".pos2"}, int'(pos2), ep2);
        check({nm, ".limitHit"}, int'(limitHit), elh);
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        bit rst;
        int t1, t2, p1, p2;
        int u1, d1, u2, d2;
        bit lh;
    } vec_t;

    vec_t tbl[6];
    int mp1, mp2, lh_m;

    initial begin
        int s_u1, s_d1, s_u2, s_d2, s_md, first;
        logic bs[11], ds[11], ss[11];

        tbl[0] = '{0, 10, -5, 10, -5, 10, 0, 0, 5, 0};
        tbl[1] = '{0, 10, -5, 10, -5, 0, 0, 0, 0, 0};
        tbl[2] = '{0, 10, 3400, 10, 3400, 0, 0, 3405, 0, 0};
`ifdef SOFT_LIMIT_EN
        tbl[3] = '{0, 10, 4000, 10, 3500, 0, 0, 100, 0, 1};
        tbl[4] = '{1, 4095, 0, 3000, 0, 3000, 0, 0, 0, 1};
        tbl[5] = '{0, -4096, 0, -3000, 0, 0, 6000, 0, 0, 1};
`else
        tbl[3] = '{0, 10, 4000, 10, 4000, 0, 0, 600, 0, 0};
        tbl[4] = '{1, 4095, 0, 4095, 0, 4095, 0, 0, 0, 0};
        tbl[5] = '{0, -4096, 0, -4096, 0, 0, 8191, 0, 0, 0};
`endif

        reset = 1'b1;
        anglesValid = 1'b0;
        th1 = '0;
        th2 = '0;
        repeat (3) @(negedge clk);
        check("reset.flags",
              int'({step1, step2, dir1, dir2, busy,
                    moveDone, overrun, limitHit}), 0);
        check("reset.pos", int'(pos1) | int'(pos2), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle.flags",
              int'({step1, step2, busy, moveDone, overrun}), 0);

        mp1 = 0; mp2 = 0; lh_m = 0;
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].rst) begin
                @(negedge clk);
                reset = 1'b1;
                repeat (2) @(negedge clk);
                reset = 1'b0;
                repeat (2) @(negedge clk);
            end
            do_move($sformatf("vec%0d", i),
                    tbl[i].t1, tbl[i].t2, tbl[i].p1, tbl[i].p2,
                    tbl[i].u1, tbl[i].d1, tbl[i].u2, tbl[i].d2,
                    int'(tbl[i].lh));
            mp1 = tbl[i].p1;
            mp2 = tbl[i].p2;
            lh_m = int'(tbl[i].lh);
        end

        // first-step latency, dir setup and pulse width
        @(negedge clk);
        s_u1 = up1; s_md = md;
        th1 = 13'(mp1 + 3);
        th2 = 13'(mp2);
        anglesValid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            bs[i] = busy; ds[i] = dir1; ss[i] = step1;
        end
        check("lat.busy1", int'(bs[1]), 0);
        check("lat.busy2", int'(bs[2]), 1);
        check("lat.dir2", int'(ds[2]), 0);
        check("lat.dir3", int'(ds[3]), 1);
        check("lat.step5", int'(ss[5]), 0);
        check("lat.step6", int'(ss[6]), 1);
        check("lat.step7", int'(ss[7]), 1);
        check("lat.step8", int'(ss[8]), 0);
        wait_done(s_md, 200, "lat");
        @(negedge clk);
        anglesValid = 1'b0;
        check("lat.up1", up1 - s_u1, 3);
        check("lat.pos1", int'(pos1), mp1 + 3);
        mp1 = mp1 + 3;
        repeat (3) @(negedge clk);

        // zero move: moveDone three cycles after the input edge
        @(negedge clk);
        s_u1 = up1; s_d1 = dn1; s_u2 = up2; s_d2 = dn2;
        th1 = 13'(mp1);
        th2 = 13'(mp2);
        anglesValid = 1'b1;
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (moveDone && first == 0) first = i;
        end
        anglesValid = 1'b0;
        check("zero.latency", first, 3);
        check("zero.steps",
              (up1 - s_u1) + (dn1 - s_d1)
              + (up2 - s_u2) + (dn2 - s_d2), 0);
        repeat (3) @(negedge clk);

        // overrun: second edge mid-move is flagged and dropped
        @(negedge clk);
        s_u1 = up1; s_d1 = dn1; s_u2 = up2; s_d2 = dn2;
        s_md = md;
        th1 = 13'(mp1 + 20);
        th2 = 13'(mp2);
        anglesValid = 1'b1;
        repeat (30) @(negedge clk);
        anglesValid = 1'b0;
        repeat (3) @(negedge clk);
        th1 = 13'(mp1 - 7);
        th2 = 13'(mp2 + 9);
        anglesValid = 1'b1;
        repeat (2) @(negedge clk);
        check("ovr.flag", int'(overrun), 1);
        wait_done(s_md, 400, "ovr");
        @(negedge clk);
        anglesValid = 1'b0;
        check("ovr.up1", up1 - s_u1, 20);
        check("ovr.other",
              (dn1 - s_d1) + (up2 - s_u2) + (dn2 - s_d2), 0);
        check("ovr.pos1", int'(pos1), mp1 + 20);
        repeat (20) @(negedge clk);
        check("ovr.idle", int'(busy), 0);
        check("ovr.pos1hold", int'(pos1), mp1 + 20);
        check("ovr.pos2hold", int'(pos2), mp2);
        mp1 = mp1 + 20;

        // reset in the middle of a 20-step move
        @(negedge clk);
        s_u1 = up1;
        th1 = 13'(mp1 + 20);
        th2 = 13'(mp2 - 20);
        anglesValid = 1'b1;
        repeat (40) @(negedge clk);
        check("rst.started", int'(up1 - s_u1 > 0), 1);
        reset = 1'b1;
        anglesValid = 1'b0;
        #1;
        check("rst.flags",
              int'({step1, step2, dir1, dir2, busy,
                    moveDone, overrun, limitHit}), 0);
        check("rst.pos1", int'(pos1), 0);
        check("rst.pos2", int'(pos2), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        mp1 = 0; mp2 = 0; lh_m = 0;
        do_move("afterrst", 5, 5, 5, 5, 5, 0, 5, 0, 0);
        mp1 = 5; mp2 = 5;

        for (int k = 0; k < 8; k++) begin
            int t1, t2, e1, e2, n1, n2;
            t1 = mp1 + int'($urandom_range(40)) - 20;
            t2 = mp2 + int'($urandom_range(40)) - 20;
            e1 = lim1(t1);
            e2 = lim2(t2);
            if (e1 != t1 || e2 != t2) lh_m = 1;
            n1 = e1 - mp1;
            n2 = e2 - mp2;
            do_move($sformatf("rnd%0d", k), t1, t2, e1, e2,
                    (n1 > 0) ? n1 : 0, (n1 < 0) ? -n1 : 0,
                    (n2 > 0) ? n2 : 0, (n2 < 0) ? -n2 : 0,
                    lh_m);
            mp1 = e1;
            mp2 = e2;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
